// File: rtl/melody_sequencer.sv
// Plays a fixed 16-entry melody into the tone divider and gives live keys priority over it.
// Melody timing freezes while a key is held or while paused; optional looping at the end.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | after reset or restart with play low; waiting for play
// PLAY   | melody running; prescaler advances while no key is held
// PAUSE  | play released; position, remaining beats and prescaler held
// DONE   | last entry finished without looping; waits for restart
module melody_sequencer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BEAT_HZ = 8,
    parameter bit          LOOP    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        restart,
    input  logic [31:0] key_div,
    output logic [31:0] out_div,
    output logic [3:0]  note_idx,
    output logic        playing,
    output logic        song_done
);

    localparam int unsigned BEAT_CYC   = (CLK_HZ / BEAT_HZ > 1) ? CLK_HZ / BEAT_HZ : 1;
    localparam int unsigned PW         = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(BEAT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc;
    logic [3:0]    remaining;
    logic          adv, tick, entry_end, song_end;
    logic [31:0]   out_div_nx;
    logic          playing_nx, song_done_nx;

    function automatic logic [3:0] rom_note(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd6, 4'd11, 4'd12: rom_note = 4'd3;
            4'd2, 4'd5:                     rom_note = 4'd4;
            4'd3, 4'd4:                     rom_note = 4'd5;
            4'd7, 4'd10, 4'd13, 4'd14:      rom_note = 4'd2;
            4'd8, 4'd9:                     rom_note = 4'd1;
            default:                        rom_note = 4'd0;
        endcase
    endfunction

    // A stored beat count of zero still plays for one beat.
    function automatic logic [3:0] rom_beats(input logic [3:0] idx);
        logic [3:0] b;
        case (idx)
            4'd12:        b = 4'd3;
            4'd13:        b = 4'd1;
            4'd14, 4'd15: b = 4'd4;
            default:      b = 4'd2;
        endcase
        rom_beats = (b == 4'd0) ? 4'd1 : b;
    endfunction

    function automatic logic [31:0] note_div(input logic [3:0] note);
        case (note)
            4'd1:    note_div = 32'd95602;
            4'd2:    note_div = 32'd85178;
            4'd3:    note_div = 32'd75872;
            4'd4:    note_div = 32'd71633;
            4'd5:    note_div = 32'd63856;
            4'd6:    note_div = 32'd56818;
            4'd7:    note_div = 32'd50658;
            4'd8:    note_div = 32'd47801;
            default: note_div = 32'd0;
        endcase
    endfunction

    assign adv       = (state == S_PLAY) && (key_div == 32'd0);
    assign tick      = adv && (presc == PRESC_LAST);
    assign entry_end = tick && (remaining == 4'd1);
    assign song_end  = entry_end && (note_idx == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (restart) begin
            state_nx = play ? S_PLAY : S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (play) state_nx = S_PLAY;
                S_PLAY: begin
                    if (song_end && !LOOP) state_nx = S_DONE;
                    else if (!play)        state_nx = S_PAUSE;
                end
                S_PAUSE: if (play) state_nx = S_PLAY;
                default: state_nx = S_DONE;
            endcase
        end
    end

    always_comb begin
        out_div_nx = 32'd0;
        if (key_div != 32'd0) begin
            out_div_nx = key_div;
        end else if (state == S_PLAY) begin
            out_div_nx = note_div(rom_note(note_idx));
        end
        playing_nx   = (state_nx == S_PLAY);
        song_done_nx = song_end && !restart;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_div   <= 32'd0;
            playing   <= 1'b0;
            song_done <= 1'b0;
        end else begin
            out_div   <= out_div_nx;
            playing   <= playing_nx;
            song_done <= song_done_nx;
        end
    end

    // Position only moves on active cycles, so pauses and key holds add no drift.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_idx  <= 4'd0;
            remaining <= rom_beats(4'd0);
            presc     <= '0;
        end else if (restart) begin
            note_idx  <= 4'd0;
            remaining <= rom_beats(4'd0);
            presc     <= '0;
        end else if (adv) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                if (remaining != 4'd1) begin
                    remaining <= remaining - 4'd1;
                end else if (note_idx != 4'd15) begin
                    note_idx  <= note_idx + 4'd1;
                    remaining <= rom_beats(note_idx + 4'd1);
                end else if (LOOP) begin
                    note_idx  <= 4'd0;
                    remaining <= rom_beats(4'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: non-looping and looping instances share stimulus and are
// checked every cycle against an elapsed-time melody model, plus directed corner cases.
module tb_melody_sequencer;

    localparam int unsigned CLK_HZ  = 8;
    localparam int unsigned BEAT_HZ = 2;
    localparam int CYC = CLK_HZ / BEAT_HZ;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    localparam int SONG_NOTE [16] = '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2, 0};
    localparam int SONG_BEATS[16] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4, 4};
    localparam int NOTE_HZ   [16] = '{0, 523, 587, 659, 698, 783, 880, 987, 1046,
                                      0, 0, 0, 0, 0, 0, 0};

    logic        clk = 1'b0;
    logic        reset, play, restart;
    logic [31:0] key_div;
    logic [31:0] out_div0, out_div1;
    logic [3:0]  note_idx0, note_idx1;
    logic        playing0, playing1, song_done0, song_done1;

    melody_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .LOOP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .play(play), .restart(restart), .key_div(key_div),
        .out_div(out_div0), .note_idx(note_idx0), .playing(playing0), .song_done(song_done0)
    );

    melody_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .LOOP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .play(play), .restart(restart), .key_div(key_div),
        .out_div(out_div1), .note_idx(note_idx1), .playing(playing1), .song_done(song_done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          mode;
        int          idx;
        int          elapsed;
        logic [31:0] out_div;
        bit          playing;
        bit          song_done;
    } model_t;

    typedef struct {
        bit          rst;
        bit          ply;
        bit          rs;
        logic [31:0] kd;
        logic [31:0] e_div;
        logic [3:0]  e_idx;
        bit          e_play;
        bit          e_done;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    model_t m0, m1;
    vec_t   vecs[16];

    function automatic int entry_cycles(input int idx);
        int b;
        b = (SONG_BEATS[idx] == 0) ? 1 : SONG_BEATS[idx];
        return b * CYC;
    endfunction

    function automatic logic [31:0] entry_div(input int idx);
        int f;
        f = NOTE_HZ[SONG_NOTE[idx]];
        return (f == 0) ? 32'd0 : 32'(50_000_000 / f);
    endfunction

    // The melody as elapsed active cycles within the current entry.
    function automatic model_t model_next(input model_t m, input bit lp, input bit rst,
                                          input bit ply, input bit rs, input logic [31:0] kd);
        model_t n;
        bit active, fin, last;
        n = m;
        if (rst) begin
            n.mode = M_IDLE; n.idx = 0; n.elapsed = 0;
            n.out_div = 32'd0; n.playing = 1'b0; n.song_done = 1'b0;
            return n;
        end
        active = (m.mode == M_PLAY) && (kd == 32'd0);
        fin    = active && (m.elapsed + 1 == entry_cycles(m.idx));
        last   = fin && (m.idx == 15);
        n.out_div   = (kd != 32'd0) ? kd : ((m.mode == M_PLAY) ? entry_div(m.idx) : 32'd0);
        n.song_done = last && !rs;
        if (rs) begin
            n.idx = 0; n.elapsed = 0;
            n.mode = ply ? M_PLAY : M_IDLE;
        end else begin
            if (active) begin
                if (fin) begin
                    n.elapsed = 0;
                    if (m.idx < 15) n.idx = m.idx + 1;
                    else if (lp)    n.idx = 0;
                end else begin
                    n.elapsed = m.elapsed + 1;
                end
            end
            if (m.mode == M_IDLE && ply)             n.mode = M_PLAY;
            else if (m.mode == M_PLAY) begin
                if (last && !lp)                     n.mode = M_DONE;
                else if (!ply)                       n.mode = M_PAUSE;
            end else if (m.mode == M_PAUSE && ply)   n.mode = M_PLAY;
        end
        n.playing = (n.mode == M_PLAY);
        return n;
    endfunction

    function automatic vec_t mk(input bit rst, input bit ply, input bit rs, input logic [31:0] kd,
                                input logic [31:0] e_div, input logic [3:0] e_idx,
                                input bit e_play, input bit e_done);
        vec_t v;
        v.rst = rst; v.ply = ply; v.rs = rs; v.kd = kd;
        v.e_div = e_div; v.e_idx = e_idx; v.e_play = e_play; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m0 = model_next(m0, 1'b0, reset, play, restart, key_div);
        m1 = model_next(m1, 1'b1, reset, play, restart, key_div);
        #1;
        chk("d0_out_div",   out_div0,          m0.out_div);
        chk("d0_note_idx",  32'(note_idx0),    32'(m0.idx));
        chk("d0_playing",   32'(playing0),     32'(m0.playing));
        chk("d0_song_done", 32'(song_done0),   32'(m0.song_done));
        chk("d1_out_div",   out_div1,          m1.out_div);
        chk("d1_note_idx",  32'(note_idx1),    32'(m1.idx));
        chk("d1_playing",   32'(playing1),     32'(m1.playing));
        chk("d1_song_done", 32'(song_done1),   32'(m1.song_done));
    endtask

    task automatic wait_idx(input logic [3:0] k);
        int n;
        n = 0;
        while (note_idx0 != k && n < 300) begin
            step();
            n++;
        end
        if (note_idx0 != k) begin
            errors++;
            $display("FAIL wait_idx_%0d: timed out, note_idx=%0d", k, note_idx0);
        end
    endtask

    task automatic measure_rest(input logic [3:0] k, output int n);
        n = 0;
        while (note_idx0 == k && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, cnt, prev, pulses0, key_len;
        int dur[16];
        bit seen;

        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 32'd0,     32'd0,     4'd0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd0,     4'd0, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd1, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'd47801, 32'd47801, 4'd1, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd1, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'd0,     32'd75872, 4'd1, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'd0,     32'd0,     4'd1, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd0,     4'd1, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 32'd0,     32'd75872, 4'd1, 1'b1, 1'b0);

        reset = 1'b1; play = 1'b0; restart = 1'b0; key_div = 32'd0;
        m0 = model_next(m0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        m1 = model_next(m1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        #2;

        for (int i = 0; i < 16; i++) begin
            reset = vecs[i].rst; play = vecs[i].ply; restart = vecs[i].rs; key_div = vecs[i].kd;
            step();
            chk($sformatf("vec%0d_out_div", i),   out_div0,          vecs[i].e_div);
            chk($sformatf("vec%0d_note_idx", i),  32'(note_idx0),    32'(vecs[i].e_idx));
            chk($sformatf("vec%0d_playing", i),   32'(playing0),     32'(vecs[i].e_play));
            chk($sformatf("vec%0d_song_done", i), 32'(song_done0),   32'(vecs[i].e_done));
        end
        reset = 1'b0; restart = 1'b0; key_div = 32'd0; play = 1'b1;

        // Key held 10 cycles inside entry 3 stretches it from 8 to 18 cycles.
        wait_idx(4'd3);
        step(); step();
        key_div = 32'd47801;
        step();
        chk("key_out_div", out_div0, 32'd47801);
        for (int i = 0; i < 9; i++) step();
        key_div = 32'd0;
        step();
        chk("key_release_div", out_div0, 32'd63856);
        measure_rest(4'd3, n);
        chk("entry3_key_len", 32'(n + 13), 32'd18);

        // Pause of 20 cycles inside entry 5 stretches it from 8 to 28 cycles.
        wait_idx(4'd5);
        step(); step(); step();
        play = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("pause_out_div", out_div0, 32'd0);
        chk("pause_playing", 32'(playing0), 32'd0);
        play = 1'b1;
        measure_rest(4'd5, n);
        chk("entry5_pause_len", 32'(n + 23), 32'd28);

        // Restart landing on the final tick of entry 7 wins over the advance.
        wait_idx(4'd7);
        n = 0;
        while (!(m0.idx == 7 && m0.elapsed == entry_cycles(7) - 1) && n < 50) begin
            step();
            n++;
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_note_idx", 32'(note_idx0), 32'd0);
        chk("restart_no_done0", 32'(song_done0), 32'd0);
        chk("restart_no_done1", 32'(song_done1), 32'd0);
        measure_rest(4'd0, n);
        chk("restart_entry0_len", 32'(n), 32'd8);

        // Run to the end of the song, timing every entry on the way.
        for (int i = 0; i < 16; i++) dur[i] = 0;
        prev = int'(note_idx0); cnt = 0; seen = 1'b0; pulses0 = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            cnt++;
            if (int'(note_idx0) != prev) begin
                dur[prev] = cnt;
                cnt = 0;
                prev = int'(note_idx0);
            end
            if (song_done0) begin
                seen = 1'b1;
                pulses0++;
                chk("wrap_done1", 32'(song_done1), 32'd1);
                chk("wrap_idx1", 32'(note_idx1), 32'd0);
                chk("done_idx0", 32'(note_idx0), 32'd15);
                chk("done_playing0", 32'(playing0), 32'd0);
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL song_end: no song_done within 400 cycles");
        end
        chk("entry12_len", 32'(dur[12]), 32'd12);
        chk("entry13_len", 32'(dur[13]), 32'd4);
        chk("entry14_len", 32'(dur[14]), 32'd16);
        step();
        chk("wrap_out_div1", out_div1, 32'd75872);
        chk("done_out_div0", out_div0, 32'd0);
        chk("done_pulse_len", 32'(song_done0), 32'd0);

        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) play = ~play;
            step();
            if (song_done0) pulses0++;
            chk("done_hold_playing", 32'(playing0), 32'd0);
        end
        chk("done_pulse_count", 32'(pulses0), 32'd1);

        // Randomised traffic against the model.
        reset = 1'b1; play = 1'b1; restart = 1'b0; key_div = 32'd0;
        step();
        reset = 1'b0;
        key_len = 0;
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            restart = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 24) == 0) play = ~play;
            if (key_len > 0) begin
                key_len--;
                if (key_len == 0) key_div = 32'd0;
            end else if ($urandom_range(0, 29) == 0) begin
                key_len = int'($urandom_range(1, 12));
                key_div = ($urandom_range(0, 1) == 0) ? 32'd47801 : ($urandom | 32'd1);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
